// File: rtl/riscv_pkg.sv
// Shared core package: XLEN, NOP encoding and icache FSM states.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] INSTR_NOP = 32'h00000013;

  typedef enum logic {
    IC_IDLE,
    IC_REFILL
  } icache_state_t;
endpackage

// File: rtl/icache_ctrl_if.sv
// Fetch lookup and memory refill signals of the instruction cache.
interface icache_ctrl_if
  import riscv_pkg::*;
();
  logic [XLEN-1:0] icache_adr_i;
  logic [31:0]     icache_instr_o;
  logic            icache_hit_o;
  logic            invalidate_i;
  logic            mem_req_o;
  logic [XLEN-1:0] mem_adr_o;
  logic            mem_ack_i;
  logic [31:0]     mem_data_i;

  modport slave (
    input  icache_adr_i, invalidate_i,
    input  mem_ack_i, mem_data_i,
    output icache_instr_o, icache_hit_o,
    output mem_req_o, mem_adr_o
  );

  modport master (
    output icache_adr_i, invalidate_i,
    output mem_ack_i, mem_data_i,
    input  icache_instr_o, icache_hit_o,
    input  mem_req_o, mem_adr_o
  );
endinterface

// File: rtl/icache_arrays.sv
// Data/tag/valid flop arrays: one combinational read port, one write port.
module icache_arrays
  import riscv_pkg::*;
#(
  parameter int NB_LINES   = 16,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(NB_LINES),
  parameter int OFF_W      = $clog2(LINE_WORDS),
  parameter int TAG_W      = XLEN - IDX_W - OFF_W - 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx_i,
  input  logic [OFF_W-1:0] rd_off_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic             rd_hit_o,
  output logic [31:0]      rd_data_o,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             tag_we_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  logic             data_we_i,
  input  logic [OFF_W-1:0] wr_off_i,
  input  logic [31:0]      wr_data_i,
  input  logic             set_valid_i,
  input  logic             inv_all_i
);
  logic [TAG_W-1:0]    tag_q  [NB_LINES];
  logic [31:0]         data_q [NB_LINES][LINE_WORDS];
  logic [NB_LINES-1:0] valid_q;

  // Tags and data carry no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (tag_we_i)  tag_q[wr_idx_i] <= wr_tag_i;
    if (data_we_i) data_q[wr_idx_i][wr_off_i] <= wr_data_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else if (inv_all_i) begin
      valid_q <= '0;
    end else if (tag_we_i) begin
      valid_q[wr_idx_i] <= 1'b0;
    end else if (set_valid_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  assign rd_hit_o  = valid_q[rd_idx_i] &&
                     (tag_q[rd_idx_i] == rd_tag_i);
  assign rd_data_o = data_q[rd_idx_i][rd_off_i];
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped icache: combinational hit path, refill FSM, fence.i flush.
module icache_ctrl
  import riscv_pkg::*;
#(
  parameter int NB_LINES   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  icache_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(NB_LINES);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int TAG_W = XLEN - IDX_W - OFF_W - 2;
  localparam int LO_W  = OFF_W + 2;

  icache_state_t   state_q, state_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic [XLEN-1:0]  base_q, base_d;
  logic             pend_q, pend_d;

  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [TAG_W-1:0] tag;
  logic             line_hit;
  logic [31:0]      line_data;
  logic             miss, last;
  logic             unused_lo;

  logic [IDX_W-1:0] wr_idx;
  logic             tag_we, data_we, set_valid;
  logic             hit, req;
  logic [31:0]      instr;
  logic [XLEN-1:0]  madr;

  assign idx = bus.icache_adr_i[LO_W +: IDX_W];
  assign off = bus.icache_adr_i[2 +: OFF_W];
  assign tag = bus.icache_adr_i[XLEN-1 -: TAG_W];
  assign unused_lo = ^bus.icache_adr_i[1:0];

  assign miss = (state_q == IC_IDLE) && !line_hit;
  assign last = (state_q == IC_REFILL) && bus.mem_ack_i &&
                (beat_q == OFF_W'(LINE_WORDS - 1));

  icache_arrays #(
    .NB_LINES   (NB_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_arrays (
    .clk         (clk),
    .reset       (reset),
    .rd_idx_i    (idx),
    .rd_off_i    (off),
    .rd_tag_i    (tag),
    .rd_hit_o    (line_hit),
    .rd_data_o   (line_data),
    .wr_idx_i    (wr_idx),
    .tag_we_i    (tag_we),
    .wr_tag_i    (tag),
    .data_we_i   (data_we),
    .wr_off_i    (beat_q),
    .wr_data_i   (bus.mem_data_i),
    .set_valid_i (set_valid),
    .inv_all_i   (bus.invalidate_i)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IC_IDLE;
      beat_q  <= '0;
      base_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      base_q  <= base_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    pend_d  = pend_q;
    unique case (state_q)
      IC_IDLE: begin
        if (miss) begin
          state_d = IC_REFILL;
          beat_d  = '0;
          base_d  = {bus.icache_adr_i[XLEN-1:LO_W],
                     {LO_W{1'b0}}};
          pend_d  = bus.invalidate_i;
        end
      end
      IC_REFILL: begin
        pend_d = pend_q | bus.invalidate_i;
        if (bus.mem_ack_i) beat_d = beat_q + OFF_W'(1);
        if (last) begin
          state_d = IC_IDLE;
          pend_d  = 1'b0;
        end
      end
      default: state_d = IC_IDLE;
    endcase
  end

  always_comb begin
    hit       = 1'b0;
    instr     = INSTR_NOP;
    req       = 1'b0;
    madr      = '0;
    wr_idx    = idx;
    tag_we    = 1'b0;
    data_we   = 1'b0;
    set_valid = 1'b0;
    unique case (state_q)
      IC_IDLE: begin
        hit    = line_hit;
        instr  = line_hit ? line_data : INSTR_NOP;
        tag_we = miss;
      end
      IC_REFILL: begin
        req     = 1'b1;
        madr    = base_q + XLEN'({beat_q, 2'b00});
        wr_idx  = base_q[LO_W +: IDX_W];
        data_we = bus.mem_ack_i;
        // A flush seen at any point of the refill keeps the line invalid.
        set_valid = last && !pend_q && !bus.invalidate_i;
      end
      default: ;
    endcase
  end

  assign bus.icache_hit_o   = hit;
  assign bus.icache_instr_o = instr;
  assign bus.mem_req_o      = req;
  assign bus.mem_adr_o      = madr;
endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: refill, hits, conflicts, flush, reset.
module tb_icache_ctrl;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  icache_ctrl_if bus();

  icache_ctrl #(
    .NB_LINES   (16),
    .LINE_WORDS (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory side of one refill; entered one tick after the refill edge.
  task automatic serve(input logic [31:0] base, input logic [31:0] d0,
                       input int gap, input int nbeats, input int inv_at,
                       input int chg_at, input logic [31:0] new_adr);
    int b = 0;
    int t = 0;
    while (b < nbeats && t < 200) begin
      if (t == chg_at) bus.icache_adr_i = new_adr;
      bus.mem_ack_i    = ((t % gap) == gap - 1);
      bus.mem_data_i   = d0 + b;
      bus.invalidate_i = bus.mem_ack_i && (b == inv_at);
      @(negedge clk);
      checks++;
      if (bus.mem_req_o !== 1'b1 || bus.mem_adr_o !== base + 4 * b ||
          bus.icache_hit_o !== 1'b0 || bus.icache_instr_o !== INSTR_NOP) begin
        errors++;
        $display("FAIL refill_beat t=%0d req=%0b adr=%h hit=%0b instr=%h exp 1/%h/0/%h",
                 t, bus.mem_req_o, bus.mem_adr_o, bus.icache_hit_o,
                 bus.icache_instr_o, base + 4 * b, INSTR_NOP);
      end
      step();
      if (bus.mem_ack_i) b++;
      t++;
    end
    bus.mem_ack_i    = 1'b0;
    bus.invalidate_i = 1'b0;
    checks++;
    if (b < nbeats) begin
      errors++;
      $display("FAIL refill_timeout beats=%0d exp %0d", b, nbeats);
    end
  endtask

  task automatic test_reset();
    reset            = 1'b1;
    bus.icache_adr_i = 32'h0;
    bus.invalidate_i = 1'b0;
    bus.mem_ack_i    = 1'b0;
    bus.mem_data_i   = 32'h0;
    step();
    step();
    checks++;
    if (bus.mem_req_o !== 1'b0 || bus.mem_adr_o !== 32'h0 ||
        bus.icache_hit_o !== 1'b0 || bus.icache_instr_o !== INSTR_NOP) begin
      errors++;
      $display("FAIL reset_outputs req=%0b adr=%h hit=%0b instr=%h exp 0/0/0/%h",
               bus.mem_req_o, bus.mem_adr_o, bus.icache_hit_o,
               bus.icache_instr_o, INSTR_NOP);
    end
    reset = 1'b0;
  endtask

  task automatic test_refill_hit();
    bus.icache_adr_i = 32'h1000;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b0 || bus.icache_instr_o !== INSTR_NOP ||
        bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL first_miss hit=%0b instr=%h req=%0b exp 0/%h/0",
               bus.icache_hit_o, bus.icache_instr_o, bus.mem_req_o, INSTR_NOP);
    end
    step();
    serve(32'h1000, 32'hA0, 1, 4, -1, -1, 32'h0);
    bus.icache_adr_i = 32'h1008;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b1 || bus.icache_instr_o !== 32'hA2) begin
      errors++;
      $display("FAIL hit_1008 hit=%0b instr=%h exp 1/000000a2",
               bus.icache_hit_o, bus.icache_instr_o);
    end
    bus.icache_adr_i = 32'h100A;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b1 || bus.icache_instr_o !== 32'hA2) begin
      errors++;
      $display("FAIL hit_100a hit=%0b instr=%h exp 1/000000a2",
               bus.icache_hit_o, bus.icache_instr_o);
    end
    bus.icache_adr_i = 32'h100C;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b1 || bus.icache_instr_o !== 32'hA3 ||
        bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL hit_100c hit=%0b instr=%h req=%0b exp 1/000000a3/0",
               bus.icache_hit_o, bus.icache_instr_o, bus.mem_req_o);
    end
  endtask

  task automatic test_conflict();
    bus.icache_adr_i = 32'h1100;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b0) begin
      errors++;
      $display("FAIL conflict_miss hit=%0b exp 0", bus.icache_hit_o);
    end
    step();
    serve(32'h1100, 32'hB0, 1, 4, -1, -1, 32'h0);
    bus.icache_adr_i = 32'h1104;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b1 || bus.icache_instr_o !== 32'hB1) begin
      errors++;
      $display("FAIL hit_1104 hit=%0b instr=%h exp 1/000000b1",
               bus.icache_hit_o, bus.icache_instr_o);
    end
    bus.icache_adr_i = 32'h1000;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b0 || bus.icache_instr_o !== INSTR_NOP) begin
      errors++;
      $display("FAIL evicted_1000 hit=%0b instr=%h exp 0/%h",
               bus.icache_hit_o, bus.icache_instr_o, INSTR_NOP);
    end
    step();
    serve(32'h1000, 32'hA0, 1, 4, -1, -1, 32'h0);
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b1 || bus.icache_instr_o !== 32'hA0) begin
      errors++;
      $display("FAIL reload_1000 hit=%0b instr=%h exp 1/000000a0",
               bus.icache_hit_o, bus.icache_instr_o);
    end
  endtask

  task automatic test_inv_idle();
    bus.icache_adr_i = 32'h1010;
    step();
    serve(32'h1010, 32'hC0, 1, 4, -1, -1, 32'h0);
    checks++;
    if (bus.icache_hit_o !== 1'b1 || bus.icache_instr_o !== 32'hC0) begin
      errors++;
      $display("FAIL hit_1010 hit=%0b instr=%h exp 1/000000c0",
               bus.icache_hit_o, bus.icache_instr_o);
    end
    bus.invalidate_i = 1'b1;
    step();
    bus.invalidate_i = 1'b0;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b0) begin
      errors++;
      $display("FAIL flushed_1010 hit=%0b exp 0", bus.icache_hit_o);
    end
    bus.icache_adr_i = 32'h1000;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b0) begin
      errors++;
      $display("FAIL flushed_1000 hit=%0b exp 0", bus.icache_hit_o);
    end
  endtask

  task automatic test_wait_states();
    step();
    serve(32'h1000, 32'hA0, 3, 4, -1, 1, 32'h2000);
    checks++;
    if (bus.icache_hit_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL miss_2000 hit=%0b req=%0b exp 0/0",
               bus.icache_hit_o, bus.mem_req_o);
    end
    step();
    serve(32'h2000, 32'hD0, 1, 4, -1, -1, 32'h0);
    bus.icache_adr_i = 32'h2004;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b1 || bus.icache_instr_o !== 32'hD1) begin
      errors++;
      $display("FAIL hit_2004 hit=%0b instr=%h exp 1/000000d1",
               bus.icache_hit_o, bus.icache_instr_o);
    end
  endtask

  task automatic test_inv_refill();
    bus.icache_adr_i = 32'h1000;
    step();
    serve(32'h1000, 32'hA0, 1, 4, 2, -1, 32'h0);
    checks++;
    if (bus.icache_hit_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL inv_refill_miss hit=%0b req=%0b exp 0/0",
               bus.icache_hit_o, bus.mem_req_o);
    end
    step();
    serve(32'h1000, 32'hA0, 1, 4, -1, -1, 32'h0);
    bus.icache_adr_i = 32'h1008;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b1 || bus.icache_instr_o !== 32'hA2) begin
      errors++;
      $display("FAIL inv_refill_rehit hit=%0b instr=%h exp 1/000000a2",
               bus.icache_hit_o, bus.icache_instr_o);
    end
  endtask

  task automatic test_reset_mid();
    bus.icache_adr_i = 32'h1010;
    step();
    serve(32'h1010, 32'hE0, 1, 1, -1, -1, 32'h0);
    checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_adr_o !== 32'h1014) begin
      errors++;
      $display("FAIL beat1_req req=%0b adr=%h exp 1/00001014",
               bus.mem_req_o, bus.mem_adr_o);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_req_o !== 1'b0 || bus.mem_adr_o !== 32'h0) begin
      errors++;
      $display("FAIL async_reset req=%0b adr=%h exp 0/00000000",
               bus.mem_req_o, bus.mem_adr_o);
    end
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_miss hit=%0b exp 0", bus.icache_hit_o);
    end
    step();
    serve(32'h1010, 32'hE0, 1, 4, -1, -1, 32'h0);
    bus.icache_adr_i = 32'h1014;
    #1;
    checks++;
    if (bus.icache_hit_o !== 1'b1 || bus.icache_instr_o !== 32'hE1) begin
      errors++;
      $display("FAIL hit_1014 hit=%0b instr=%h exp 1/000000e1",
               bus.icache_hit_o, bus.icache_instr_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_refill_hit();
    test_conflict();
    test_inv_idle();
    test_wait_states();
    test_inv_refill();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
